// File: rtl/mtm_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | mtm_alu_sequencer
// | Frame controller: decodes a frame, runs the ALU, computes the CRC-3 and
// | streams result or error bytes to the serializer over ready/valid.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module mtm_alu_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        frame_valid_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [7:0]  ctl_i,
  output logic        alu_start_o,
  output logic [2:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic        alu_done_i,
  input  logic [31:0] alu_c_i,
  input  logic [3:0]  alu_flags_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_is_ctl_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic [7:0]  drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_EXEC, S_WAIT, S_CRC, S_TX_DATA, S_TX_CTL, S_TX_ERR
  } state_e;

  localparam logic [7:0] C_TIMEOUT  = 8'(ALU_TIMEOUT);
  // Error bytes {1, ed, ec, eo, ed, ec, eo, parity}
  localparam logic [7:0] C_ERR_DATA = 8'hC9;
  localparam logic [7:0] C_ERR_CRC  = 8'hA5;
  localparam logic [7:0] C_ERR_OP   = 8'h93;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0]  ctl_q, ctl_d, err_q, err_d, cnt_q, cnt_d, drop_q, drop_d;
  logic [3:0]  flags_q, flags_d;
  logic [2:0]  crc_q, crc_d;

  logic [36:0] w_msg;
  logic        w_bit, w_fb, w_op_ok;

  assign w_msg   = {c_q, 1'b0, flags_q};
  assign w_bit   = w_msg[6'd36 - cnt_q[5:0]];
  assign w_fb    = w_bit ^ crc_q[2];
  assign w_op_ok = ctl_q[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101};

  assign alu_op_o   = ctl_q[6:4];
  assign alu_a_o    = a_q;
  assign alu_b_o    = b_q;
  assign busy_o     = (state_q != S_IDLE);
  assign drop_cnt_o = drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      ctl_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
      flags_q <= '0;
      crc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ctl_q   <= ctl_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      flags_q <= flags_d;
      crc_q   <= crc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    ctl_d       = ctl_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    flags_d     = flags_q;
    crc_d       = crc_q;
    drop_d      = drop_q;
    alu_start_o = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    tx_is_ctl_o = 1'b0;

    if (frame_valid_i && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          ctl_d   = ctl_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ctl_q == C_ERR_DATA) begin
          err_d   = C_ERR_DATA;
          state_d = S_TX_ERR;
        end else if (ctl_q == C_ERR_CRC) begin
          err_d   = C_ERR_CRC;
          state_d = S_TX_ERR;
        end else if (!w_op_ok) begin
          err_d   = C_ERR_OP;
          state_d = S_TX_ERR;
        end else begin
          state_d = S_EXEC;
        end
      end
      // cnt_q holds the index of the current wait cycle, EXEC being cycle 1
      S_EXEC, S_WAIT: begin
        alu_start_o = (state_q == S_EXEC);
        if (alu_done_i) begin
          c_d     = alu_c_i;
          flags_d = alu_flags_i;
          crc_d   = 3'b000;
          cnt_d   = 8'd0;
          state_d = S_CRC;
        end else if (((state_q == S_EXEC) ? 8'd1 : cnt_q) >= C_TIMEOUT) begin
          err_d   = C_ERR_OP;
          state_d = S_TX_ERR;
        end else begin
          cnt_d   = (state_q == S_EXEC) ? 8'd2 : cnt_q + 8'd1;
          state_d = S_WAIT;
        end
      end
      S_CRC: begin
        crc_d = {crc_q[1], crc_q[0] ^ w_fb, w_fb};
        if (cnt_q == 8'd36) begin
          cnt_d   = 8'd0;
          state_d = S_TX_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TX_DATA: begin
        tx_valid_o = 1'b1;
        case (cnt_q[1:0])
          2'd0:    tx_data_o = c_q[31:24];
          2'd1:    tx_data_o = c_q[23:16];
          2'd2:    tx_data_o = c_q[15:8];
          default: tx_data_o = c_q[7:0];
        endcase
        if (tx_ready_i) begin
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d   = 8'd0;
            state_d = S_TX_CTL;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_TX_CTL: begin
        tx_valid_o  = 1'b1;
        tx_is_ctl_o = 1'b1;
        tx_data_o   = {1'b0, flags_q, crc_q};
        if (tx_ready_i) state_d = S_IDLE;
      end
      S_TX_ERR: begin
        tx_valid_o  = 1'b1;
        tx_is_ctl_o = 1'b1;
        tx_data_o   = err_q;
        if (tx_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_mtm_alu_sequencer
// | Self-checking bench: ALU stub, ready generator and a byte-queue model.
// | Revision: 1.0
// +----------------------------------------------------------------------------
module tb_mtm_alu_sequencer;
  localparam int TMO = 15;

  logic        clk = 1'b0, rst_n = 1'b0, frame_valid = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic [7:0]  ctl_in = '0;
  logic        alu_start, alu_done = 1'b0, tx_valid, tx_is_ctl, busy;
  logic        tx_ready = 1'b1;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_c = '0;
  logic [3:0]  alu_flags = '0;
  logic [7:0]  tx_data, drop_cnt;

  mtm_alu_sequencer #(.ALU_TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .frame_valid_i(frame_valid),
    .a_i(a_in), .b_i(b_in), .ctl_i(ctl_in),
    .alu_start_o(alu_start), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_done_i(alu_done), .alu_c_i(alu_c), .alu_flags_i(alu_flags),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_is_ctl_o(tx_is_ctl),
    .tx_ready_i(tx_ready), .busy_o(busy), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [8:0] exp_q[$];
  int exp_drops = 0;
  int alu_lat = 0;
  logic late_req = 1'b0;
  logic [31:0] exp_a = '0, exp_b = '0, exp_c = '0;
  logic [2:0]  exp_op = '0;
  logic [3:0]  exp_f = '0;
  int ready_mode = 0, stall_len = 10, accepted = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Remainder of (37-bit message * x^3) modulo x^3+x+1, by long division
  function automatic logic [2:0] crc3(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] m;
    m = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    return m[2:0];
  endfunction

  function automatic logic [7:0] classify(input logic [7:0] c);
    if (c == 8'hC9) return 8'hC9;
    if (c == 8'hA5) return 8'hA5;
    if (c[6:4] == 3'd0 || c[6:4] == 3'd1 || c[6:4] == 3'd4 || c[6:4] == 3'd5) return 8'h00;
    return 8'h93;
  endfunction

  task automatic alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] c, output logic [3:0] f);
    logic [32:0] s;
    logic cy, ov;
    cy = 1'b0; ov = 1'b0; c = '0;
    case (op)
      3'd0: c = a & b;
      3'd1: c = a | b;
      3'd4: begin s = {1'b0, a} + {1'b0, b}; c = s[31:0]; cy = s[32];
                  ov = (a[31] == b[31]) && (c[31] != a[31]); end
      3'd5: begin s = {1'b0, a} - {1'b0, b}; c = s[31:0]; cy = s[32];
                  ov = (a[31] != b[31]) && (c[31] != a[31]); end
      default: c = '0;
    endcase
    f = {cy, ov, c == 32'd0, c[31]};
  endtask

  // Pushes the expected byte stream, then pulses frame_valid (sampled at the next edge)
  task automatic send_frame(input logic [31:0] fa, input logic [31:0] fb, input logic [7:0] fc,
                            input int lat);
    logic [7:0] e;
    logic [31:0] c;
    logic [3:0] f;
    e = classify(fc);
    alu_model(fc[6:4], fa, fb, c, f);
    exp_a = fa; exp_b = fb; exp_op = fc[6:4]; exp_c = c; exp_f = f; alu_lat = lat;
    if (e != 8'h00) exp_q.push_back({1'b1, e});
    else if (lat < 0 || lat >= TMO) exp_q.push_back({1'b1, 8'h93});
    else begin
      exp_q.push_back({1'b0, c[31:24]}); exp_q.push_back({1'b0, c[23:16]});
      exp_q.push_back({1'b0, c[15:8]});  exp_q.push_back({1'b0, c[7:0]});
      exp_q.push_back({1'b1, 1'b0, f, crc3(c, f)});
    end
    @(posedge clk); #1;
    frame_valid = 1'b1; a_in = fa; b_in = fb; ctl_in = fc;
    @(posedge clk); #1;
    frame_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin @(negedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL wait_idle: %0d bytes outstanding after %0d cycles", exp_q.size(), bound);
      exp_q.delete();
    end
    @(negedge clk); #1;
    chk("busy_idle", busy, 0);
    chk("drop_cnt", drop_cnt, exp_drops);
  endtask

  // ALU stub: answers alu_start after alu_lat cycles (0 = in the EXEC cycle)
  int cd = -1;
  always @(negedge clk) begin
    alu_done = 1'b0;
    if (!rst_n) cd = -1;
    else if (alu_start) begin
      chk("alu_a", alu_a, exp_a);
      chk("alu_b", alu_b, exp_b);
      chk("alu_op", alu_op, exp_op);
      cd = alu_lat;
    end else if (cd > 0) cd--;
    if (cd == 0) begin alu_done = 1'b1; alu_c = exp_c; alu_flags = exp_f; cd = -1; end
    if (late_req) begin alu_done = 1'b1; alu_c = 32'hDEADBEEF; alu_flags = 4'hF; late_req = 1'b0; end
  end

  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: tx_ready = 1'b1;
      2: tx_ready = 1'($urandom % 2);
      default: begin
        if (tx_valid && wcnt >= stall_len) begin tx_ready = 1'b1; wcnt = 0; end
        else begin tx_ready = 1'b0; if (tx_valid) wcnt++; end
      end
    endcase
  end

  // Scoreboard: every accepted byte must be the next expected one; stalled bytes must hold
  logic       prev_pend = 1'b0;
  logic [8:0] prev_byte = '0, exp_b9;
  always @(negedge clk) begin
    if (!rst_n) prev_pend = 1'b0;
    else begin
      if (prev_pend) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_byte", {tx_is_ctl, tx_data}, prev_byte);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected: got 0x%0h expected no byte", {tx_is_ctl, tx_data});
        end else begin
          exp_b9 = exp_q.pop_front();
          chk("tx_byte", {tx_is_ctl, tx_data}, exp_b9);
        end
        accepted++;
      end
      prev_pend = tx_valid && !tx_ready;
      prev_byte = {tx_is_ctl, tx_data};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] rc;
    chk("crc_model_add", crc3(32'd3, 4'd0), 3'd6);
    chk("crc_model_flag", crc3(32'd0, 4'd1), 3'd3);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_outs", {alu_start, tx_is_ctl, tx_data, alu_op, drop_cnt}, 0);
    chk("rst_ops", {alu_a, alu_b}, 0);

    // ADD 1+2 with a combinational ALU
    send_frame(32'd1, 32'd2, 8'h40, 0);
    @(negedge clk); #1;
    chk("add_n1_busy", busy, 1);
    chk("add_n1_start", alu_start, 0);
    @(negedge clk); #1;
    chk("add_n2_start", alu_start, 1);
    chk("add_n2_ops", {alu_op, alu_a, alu_b}, {3'd4, 32'd1, 32'd2});
    repeat (37) @(negedge clk);
    #1 chk("add_n39_valid", tx_valid, 0);
    @(negedge clk); #1;
    chk("add_n40_first", {tx_valid, tx_is_ctl, tx_data}, {1'b1, 1'b0, 8'h00});
    wait_idle(200);

    // Error frames: byte presented in cycle n+2, no launch
    for (int k = 0; k < 3; k++) begin
      rc = (k == 0) ? 8'hC9 : (k == 1) ? 8'hA5 : 8'h70;
      send_frame($urandom, $urandom, rc, 0);
      @(negedge clk); #1;
      chk("err_n1_valid", tx_valid, 0);
      @(negedge clk); #1;
      chk("err_n2_byte", {tx_valid, tx_is_ctl, tx_data}, {1'b1, 1'b1, (k == 0) ? 8'hC9 : (k == 1) ? 8'hA5 : 8'h93});
      chk("err_n2_start", alu_start, 0);
      wait_idle(50);
    end

    // Timeout: last allowed cycle, one beyond, never, then a stray late done
    send_frame(32'h11, 32'h22, 8'h10, TMO - 1); wait_idle(200);
    send_frame(32'h11, 32'h22, 8'h10, TMO);     wait_idle(200);
    send_frame(32'h33, 32'h44, 8'h00, -1);      wait_idle(200);
    late_req = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("late_done_ignored", {busy, tx_valid}, 0);

    // Long stalls on every byte
    ready_mode = 1; stall_len = 10;
    send_frame(32'h80000000, 32'h00000001, 8'h50, 4);
    wait_idle(500);

    // Drops while busy
    stall_len = 150;
    send_frame(32'hCAFEF00D, 32'h12345678, 8'h40, 2);
    for (int i = 0; i < 300; i++) begin
      frame_valid = 1'b1; a_in = $urandom; ctl_in = 8'h40;
      @(posedge clk); #1 frame_valid = 1'b0;
      @(posedge clk); #1;
    end
    exp_drops = 255;
    chk("drop_sat", drop_cnt, 255);
    wait_idle(3000);

    // Asynchronous reset while TX_DATA byte 2 is on offer
    stall_len = 10;
    base = accepted;
    send_frame(32'hA1B2C3D4, 32'h01020304, 8'h10, 3);
    for (int n = 0; n < 500 && accepted < base + 2; n++) @(negedge clk);
    chk("rst_point", accepted - base, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", {tx_valid, tx_is_ctl, tx_data}, 0);
    chk("arst_busy_drop", {busy, drop_cnt}, 0);
    chk("arst_alu", {alu_start, alu_op, alu_a, alu_b}, 0);
    exp_q.delete(); exp_drops = 0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    ready_mode = 0;
    send_frame(32'd7, 32'd5, 8'h50, 1);
    wait_idle(200);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      ready_mode = ($urandom % 2 == 0) ? 0 : 2;
      case ($urandom_range(0, 9))
        0: rc = 8'hC9;
        1: rc = 8'hA5;
        default: rc = 8'($urandom);
      endcase
      send_frame($urandom, $urandom, rc, int'($urandom_range(0, 17)));
      wait_idle(500);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mtm_alu_sequencer.md
# mtm_alu_sequencer

Frame-level controller between the serial-input deserializer and the ALU core/output serializer. It accepts one decoded frame (A, B, CTL) at a time and classifies it as a valid operation or an error. For a valid operation it launches the ALU, waits for the result, and computes the output CRC-3. It then schedules the result bytes or an error byte through a ready/valid handshake to the serializer.

## Interface
- ALU_TIMEOUT, 15: maximum cycles, counted from the alu_start cycle inclusive, to wait for alu_done (1..255).
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- frame_valid  in  1  single-cycle pulse: A, B and CTL hold a complete frame.
- A, B  in  32 each  operands from the deserializer.
- CTL  in  8  control byte; 0xC9 = data error, 0xA5 = CRC error, else CTL[6:4] = op.
- alu_start  out  1  one-cycle launch pulse.
- alu_op  out  3  captured op.
- alu_a, alu_b  out  32 each  captured operands, stable from DECODE until IDLE.
- alu_done  in  1  result valid.
- alu_c  in  32  result.
- alu_flags  in  4  {carry, overflow, zero, negative}.
- tx_valid  out  1  byte offered to the serializer.
- tx_data  out  8  byte.
- tx_is_ctl  out  1  1 = control/error byte, 0 = data byte.
- tx_ready  in  1  serializer accepts on the edge where tx_valid && tx_ready.
- busy  out  1  state != IDLE.
- drop_cnt  out  8  frames dropped while busy; saturates at 255.

## Operation
- Reset values: state IDLE; alu_start, tx_valid, tx_is_ctl and busy = 0; tx_data, alu_a, alu_b, alu_op and drop_cnt = 0.
- States: IDLE, DECODE, EXEC, WAIT, CRC, TX_DATA, TX_CTL, TX_ERR.
- IDLE: on frame_valid, capture A, B and CTL, then go to DECODE. frame_valid in any other state is dropped and drop_cnt increments.
- DECODE classifies the captured CTL in this priority order:
  - CTL == 0xC9: error byte 0xC9.
  - CTL == 0xA5: error byte 0xA5.
  - CTL[6:4] not in {000 AND, 001 OR, 100 ADD, 101 SUB}: error byte 0x93.
  - Otherwise go to EXEC.
- All error paths go to TX_ERR.
- Error byte format is {1, ed, ec, eo, ed, ec, eo, p}, where p is the XOR of bits 7..1.
- EXEC: alu_start = 1 for exactly one cycle, then go to WAIT. alu_done is sampled from the EXEC cycle onward.
- On alu_done, latch alu_c and alu_flags and go to CRC.
- If ALU_TIMEOUT cycles elapse without alu_done, go to TX_ERR with byte 0x93. A late alu_done is ignored.
- CRC: a serial Galois LFSR, polynomial x^3+x+1, init 000, runs over 37 bits MSB-first: C[31:0], then 0, then flags[3:0].
  - Per bit b: fb = b ^ crc[2]; crc <= {crc[1], crc[0]^fb, fb}.
  - Takes exactly 37 cycles.
- TX_DATA: send C[31:24], C[23:16], C[15:8], C[7:0] with tx_is_ctl = 0.
- TX_CTL: send {0, flags[3:0], crc[2:0]} with tx_is_ctl = 1, then go to IDLE.
- TX_ERR: send the error byte with tx_is_ctl = 1, then go to IDLE.

## Timing
- frame_valid is sampled at edge n:
  - DECODE during cycle n+1.
  - alu_start high during cycle n+2.
  - For error frames, tx_valid is high from cycle n+2.
- alu_done sampled at edge m: CRC runs during cycles m+1..m+37, and the first tx_valid is in cycle m+38.
- A combinational ALU returning alu_done in the EXEC cycle gives m = n+2.
- Handshake rules:
  - While tx_valid = 1, tx_data and tx_is_ctl are stable until the accepting edge.
  - The next byte is presented in the cycle after acceptance.
  - tx_valid is never deasserted without acceptance.
- Back-to-back: the state is IDLE only in the cycle after the final acceptance. A frame_valid coincident with the final accepting edge is dropped.
- drop_cnt increments on the edge frame_valid is sampled while state != IDLE, and holds at 255.
- Asynchronous reset mid-frame or mid-handshake returns immediately to reset values. The partially sent frame is abandoned and no byte is repeated after release.

## Test plan
- A=1, B=2, CTL op=100 (ADD), alu returns C=0x00000003, flags 0000, tx_ready=1 -> bytes 0x00, 0x00, 0x00, 0x03 (tx_is_ctl=0), then 0x06 (tx_is_ctl=1); busy drops afterwards.
- CTL=0xC9 -> single byte 0xC9 with tx_is_ctl=1 in cycle n+2, no alu_start. CTL=0xA5 -> 0xA5. CTL op=111 -> 0x93.
- ALU_TIMEOUT=15 with alu_done never asserted -> 0x93 emitted, and a later alu_done pulse is ignored.
- tx_ready held low for 10 cycles per byte -> each byte is stable during the stall, and the five bytes arrive in order with no duplicates.
- 300 frame_valid pulses while busy -> drop_cnt=255, and the in-flight result is unaffected.
- rst low during TX_DATA byte 2 -> all outputs at reset values asynchronously; a subsequent frame is processed normally from IDLE.
